bht_update_ctrl: RTL and testbench

// - Controller in front of bht_data_array (2-bit counters, 256 entries, reset value 2'b10).
// - Fetch side: drives the array read index and returns a same-cycle taken/not-taken prediction.
// - Resolve side: queues resolved-branch updates in a small FIFO.
// - Each update is applied as a read-modify-write (saturating counter) using idle array cycles.
// - Forces a fetch stall only when updates have been starved for too long.

---
 rtl/bht_update_ctrl.sv | 152 +++++++++++++++
 tb/tb_bht_update_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bht_update_ctrl.sv
// Branch history table update controller: same-cycle fetch prediction plus FIFO-queued
// read-modify-write counter updates in idle array cycles. Define BHT_GSHARE_EN for gshare indexing.
module bht_update_ctrl #(
    parameter int IDXW         = 8,
    parameter int UPD_DEPTH    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_req,
    input  logic [31:0]     fetch_pc,
    output logic            pred_taken,
    output logic [IDXW-1:0] pred_idx,
    output logic            fetch_stall,
    input  logic            upd_valid,
    output logic            upd_ready,
    input  logic [IDXW-1:0] upd_idx,
    input  logic            upd_taken,
    output logic [IDXW-1:0] arr_rindex,
    output logic [IDXW-1:0] arr_windex,
    output logic            arr_write_en,
    output logic [1:0]      arr_datain,
    input  logic [1:0]      arr_dataout
);
    localparam int PW = $clog2(UPD_DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [PW:0]   FULL_CNT = UPD_DEPTH[PW:0];
    localparam logic [SW-1:0] LIMIT    = STARVE_LIMIT[SW-1:0];

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;
    state_t state, state_nxt;

    logic [IDXW-1:0] fifo_idx   [UPD_DEPTH];
    logic            fifo_taken [UPD_DEPTH];
    logic [PW:0]     wr_ptr, rd_ptr, count;
    logic            empty, full, push, pop;
    logic [IDXW-1:0] head_idx;
    logic            head_taken;

    logic [IDXW-1:0] fetch_idx;
    logic            fetch_active, slot_free;
    logic [1:0]      cnt;
    logic [SW-1:0]   starve_cnt;
    logic            we, latch, starve_inc, starve_clr;
    logic            unused_pc;

    function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
        if (t) return (c == 2'b11) ? c : c + 2'b01;
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    assign unused_pc = ^{fetch_pc[31:IDXW+2], fetch_pc[1:0]};

`ifdef BHT_GSHARE_EN
    logic [IDXW-1:0] ghr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    ghr <= '0;
        else if (push) ghr <= {ghr[IDXW-2:0], upd_taken};
    end

    assign fetch_idx = fetch_pc[IDXW+1:2] ^ ghr;
`else
    assign fetch_idx = fetch_pc[IDXW+1:2];
`endif

    // FIFO of pending updates; pointers carry an extra wrap bit
    assign count      = wr_ptr - rd_ptr;
    assign empty      = (count == '0);
    assign full       = (count == FULL_CNT);
    assign upd_ready  = !full;
    assign push       = upd_valid && upd_ready;
    assign pop        = we;
    assign head_idx   = fifo_idx[rd_ptr[PW-1:0]];
    assign head_taken = fifo_taken[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < UPD_DEPTH; i++) begin
                fifo_idx[i]   <= '0;
                fifo_taken[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_idx[wr_ptr[PW-1:0]]   <= upd_idx;
                fifo_taken[wr_ptr[PW-1:0]] <= upd_taken;
                wr_ptr                     <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // The array port is free unless an unstalled fetch reads a different index;
    // a matching index lets the write bypass straight into the prediction.
    assign fetch_active = fetch_req && !fetch_stall;
    assign slot_free    = !fetch_active || (fetch_idx == head_idx);

    assign pred_idx     = fetch_idx;
    assign arr_rindex   = fetch_active ? fetch_idx : head_idx;
    assign pred_taken   = fetch_active && arr_dataout[1];
    assign arr_windex   = head_idx;
    assign arr_datain   = cnt;
    assign arr_write_en = we;

    always_comb begin
        state_nxt  = state;
        we         = 1'b0;
        latch      = 1'b0;
        starve_inc = 1'b0;
        starve_clr = 1'b0;
        case (state)
            IDLE: if (!empty) state_nxt = RD;
            RD: begin
                if (slot_free) begin
                    latch     = 1'b1;
                    state_nxt = WR;
                end else begin
                    starve_inc = 1'b1;
                end
            end
            WR: begin
                if (slot_free) begin
                    we         = 1'b1;
                    starve_clr = 1'b1;
                    state_nxt  = (count > 1 || push) ? RD : IDLE;
                end else begin
                    starve_inc = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 2'b10;
            starve_cnt  <= '0;
            fetch_stall <= 1'b0;
        end else begin
            state <= state_nxt;
            if (latch) cnt <= sat(arr_dataout, head_taken);
            if (starve_clr)
                starve_cnt <= '0;
            else if (starve_inc && starve_cnt < LIMIT)
                starve_cnt <= starve_cnt + 1'b1;
            fetch_stall <= (starve_cnt >= LIMIT);
        end
    end
endmodule

// File: tb/tb_bht_update_ctrl.sv
// Directed bench for bht_update_ctrl: expected array writes are queued at push time and
// checked by a negedge monitor against a behavioural model of the counter array.
module tb_bht_update_ctrl;
    typedef struct packed {
        logic [7:0] idx;
        logic [1:0] val;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        pred_taken, fetch_stall, upd_ready, arr_write_en;
    logic [7:0]  pred_idx, arr_rindex, arr_windex;
    logic        upd_valid = 1'b0;
    logic [7:0]  upd_idx = '0;
    logic        upd_taken = 1'b0;
    logic [1:0]  arr_datain, arr_dataout;

    logic [1:0]  mem [256] = '{default: 2'b10};
    wr_t         exp_q [$];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    // Array model: combinational read, write data bypasses to dataout while writing
    assign arr_dataout = arr_write_en ? arr_datain : mem[arr_rindex];
    always @(posedge clk) if (arr_write_en) mem[arr_windex] <= arr_datain;

    bht_update_ctrl dut (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_idx(pred_idx), .fetch_stall(fetch_stall),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .arr_rindex(arr_rindex), .arr_windex(arr_windex), .arr_write_en(arr_write_en),
        .arr_datain(arr_datain), .arr_dataout(arr_dataout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] idx, input logic tk, input logic [1:0] val, input bit expect_wr);
        upd_valid = 1'b1;
        upd_idx   = idx;
        upd_taken = tk;
        if (expect_wr) exp_q.push_back('{idx: idx, val: val});
        tick();
        upd_valid = 1'b0;
    endtask

    // Monitor: every array write must be legal and match the next queued expectation
    always @(negedge clk) begin
        if (arr_write_en) begin
            wr_t e;
            if (fetch_req && !fetch_stall) check("wr_legal", arr_windex, fetch_pc[9:2]);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got idx=%0h val=%0b expected none", arr_windex, arr_datain);
            end else begin
                e = exp_q.pop_front();
                check("wr_idx", arr_windex, e.idx);
                check("wr_val", arr_datain, e.val);
            end
        end
    end

    initial begin
        int first_stall, first_we, stall_off;

        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", fetch_stall, 0);
        check("rst_ready", upd_ready, 1);
        check("rst_we", arr_write_en, 0);
        check("rst_datain", arr_datain, 2'b10);
        check("rst_windex", arr_windex, 0);
        rst_n = 1'b1;
        tick();

        // Prediction straight after reset
        fetch_req = 1'b1;
        fetch_pc  = 32'h40;
        #1;
        check("pred_idx", pred_idx, 8'h10);
        check("pred_taken", pred_taken, 1);
        check("pred_stall", fetch_stall, 0);
        check("pred_ready", upd_ready, 1);
        fetch_req = 1'b0;
        #1;
        check("pred_idle", pred_taken, 0);

        // Single taken update: write lands three edges after the push edge
        push(8'h10, 1'b1, 2'b11, 1'b1);
        check("lat_c1", arr_write_en, 0);
        tick();
        check("lat_c2", arr_write_en, 0);
        tick();
        check("lat_c3", arr_write_en, 1);
        repeat (3) tick();
        push(8'h10, 1'b1, 2'b11, 1'b1);
        repeat (5) tick();

        // Four back-to-back not-taken updates to idx 5
        for (int i = 0; i < 4; i++) begin
            check("b2b_ready", upd_ready, 1);
            push(8'h05, 1'b0, (i == 0) ? 2'b01 : 2'b00, 1'b1);
        end
        repeat (12) tick();

        // Fill the FIFO while fetch holds the port; a fifth offer is refused
        fetch_req = 1'b1;
        fetch_pc  = 32'h80;
        push(8'h03, 1'b1, 2'b11, 1'b1);
        push(8'h03, 1'b1, 2'b11, 1'b1);
        push(8'h03, 1'b0, 2'b10, 1'b1);
        push(8'h03, 1'b0, 2'b01, 1'b1);
        check("full_ready", upd_ready, 0);
        push(8'h03, 1'b1, 2'b00, 1'b0);
        check("full_hold", upd_ready, 0);
        fetch_req = 1'b0;
        repeat (20) tick();
        check("full_drain", exp_q.size(), 0);

        // Starvation: fetch to 0x20 blocks an update to idx 7
        fetch_req = 1'b1;
        fetch_pc  = 32'h80;
        push(8'h07, 1'b1, 2'b11, 1'b1);
        first_stall = -1;
        first_we    = -1;
        stall_off   = -1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (fetch_stall && first_stall < 0) begin
                first_stall = k;
                check("stall_pred", pred_taken, 0);
            end
            if (arr_write_en && first_we < 0) first_we = k;
            if (!fetch_stall && first_stall > 0 && stall_off < 0) stall_off = k;
        end
        check("stall_on", first_stall, 10);
        check("stall_we", first_we, 11);
        check("stall_off", stall_off, 13);
        fetch_req = 1'b0;
        repeat (3) tick();

        // Fetch to idx 9 while its write is pending: bypassed counter predicts not-taken
        push(8'h09, 1'b0, 2'b01, 1'b1);
        tick();
        tick();
        fetch_req = 1'b1;
        fetch_pc  = 32'h24;
        #1;
        check("byp_we", arr_write_en, 1);
        check("byp_pred", pred_taken, 0);
        check("byp_idx", pred_idx, 8'h09);
        check("byp_stall", fetch_stall, 0);
        tick();
        fetch_req = 1'b0;
        repeat (3) tick();

        // Reset with three queued updates: all dropped
        fetch_req = 1'b1;
        fetch_pc  = 32'h80;
        push(8'h01, 1'b1, 2'b00, 1'b0);
        push(8'h02, 1'b1, 2'b00, 1'b0);
        push(8'h03, 1'b1, 2'b00, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_we", arr_write_en, 0);
        check("arst_ready", upd_ready, 1);
        check("arst_datain", arr_datain, 2'b10);
        check("arst_windex", arr_windex, 0);
        fetch_req = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("arst_ready2", upd_ready, 1);
        fetch_req = 1'b1;
        fetch_pc  = 32'h40;
        #1;
        check("arst_pidx", pred_idx, 8'h10);
        fetch_req = 1'b0;
        tick();

        check("final_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
